// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared memory-bus types for the memory-side arbiter.
//   ADDR / MEM_TAG / MEM_BLOCK / MEM_COMMAND : memory bus field types.
//   OWNER_T : which client owns an outstanding load tag.
//   NUM_MEM_TAGS / CNT_W : tag count and outstanding-counter width.
package mem_arbiter_pkg;

    localparam int NUM_MEM_TAGS = 15;
    localparam int TAG_W        = $clog2(NUM_MEM_TAGS + 1);
    localparam int CNT_W        = $clog2(NUM_MEM_TAGS + 1);

    typedef logic [31:0]      ADDR;
    typedef logic [TAG_W-1:0] MEM_TAG;
    typedef logic [63:0]      MEM_BLOCK;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } MEM_COMMAND;

    typedef enum logic {
        FETCH  = 1'b0,
        DCACHE = 1'b1
    } OWNER_T;

    // A tag names a real table entry only when it is 1..n.
    function automatic logic tag_ok(MEM_TAG t, int n);
        return (t != '0) && (int'(t) <= n);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, dcache and memory-side signals of the
// arbiter.
//   slave  : arbiter view (client/memory requests in, grants/tags/bus out).
//   master : environment view (fetch, dcache and memory models).
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // fetch client
    logic             fetch_mem_en;
    ADDR              fetch_mem_addr;
    logic             fetch_grant;
    MEM_TAG           fetch_transaction_tag;
    MEM_TAG           fetch_data_tag;
    MEM_BLOCK         fetch_data;
    logic [CNT_W-1:0] fetch_outstanding;

    // dcache client
    logic             dcache_req;
    MEM_COMMAND       dcache_command;
    ADDR              dcache_addr;
    MEM_BLOCK         dcache_store_data;
    logic             dcache_grant;
    MEM_TAG           dcache_transaction_tag;
    MEM_TAG           dcache_data_tag;
    MEM_BLOCK         dcache_data;
    logic [CNT_W-1:0] dcache_outstanding;

    // memory side
    MEM_COMMAND       proc2mem_command;
    ADDR              proc2mem_addr;
    MEM_BLOCK         proc2mem_data;
    MEM_TAG           mem2proc_transaction_tag;
    MEM_TAG           mem2proc_data_tag;
    MEM_BLOCK         mem2proc_data;

    logic             error;

    modport slave (
        input  fetch_mem_en, fetch_mem_addr,
        input  dcache_req, dcache_command, dcache_addr, dcache_store_data,
        input  mem2proc_transaction_tag, mem2proc_data_tag, mem2proc_data,
        output fetch_grant, fetch_transaction_tag, fetch_data_tag, fetch_data,
        output fetch_outstanding,
        output dcache_grant, dcache_transaction_tag, dcache_data_tag, dcache_data,
        output dcache_outstanding,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output error
    );

    modport master (
        output fetch_mem_en, fetch_mem_addr,
        output dcache_req, dcache_command, dcache_addr, dcache_store_data,
        output mem2proc_transaction_tag, mem2proc_data_tag, mem2proc_data,
        input  fetch_grant, fetch_transaction_tag, fetch_data_tag, fetch_data,
        input  fetch_outstanding,
        input  dcache_grant, dcache_transaction_tag, dcache_data_tag, dcache_data,
        input  dcache_outstanding,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  error
    );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single memory port to fetch or dcache each cycle,
// forwards the winner's request combinationally, returns the accepted tag
// to the winner, tracks per-tag load ownership and routes returning data
// tags to their owner.
//   clock, reset : system clock, synchronous active-high reset.
//   bus (slave)  : fetch / dcache client ports, memory bus, outstanding
//                  counters and sticky error flag.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_MEM_TAGS = mem_arbiter_pkg::NUM_MEM_TAGS,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak;

    // Grants depend only on registered streak and dcache_req, never on
    // fetch_mem_en, so fetch can decide its request after seeing its grant.
    logic dcache_grant, fetch_grant;
    assign dcache_grant = bus.dcache_req & (streak != STREAK_MAX);
    assign fetch_grant  = ~dcache_grant;

    // Request path
    MEM_COMMAND cmd;
    ADDR        addr;
    MEM_BLOCK   wdata;

    always_comb begin
        cmd   = MEM_NONE;
        addr  = '0;
        wdata = '0;
        if (dcache_grant) begin
            cmd   = bus.dcache_command;
            addr  = bus.dcache_addr;
            wdata = bus.dcache_store_data;
        end else if (bus.fetch_mem_en) begin
            cmd   = MEM_LOAD;
            addr  = bus.fetch_mem_addr;
        end
    end

    MEM_TAG tt;
    logic   accepted, load_acc;
    assign tt       = bus.mem2proc_transaction_tag;
    assign accepted = (cmd != MEM_NONE) && (tt != '0);
    // Only loads get an owner entry; the tag range guard keeps the table
    // index legal if memory hands out a tag beyond the table.
    assign load_acc = accepted && (cmd == MEM_LOAD) && tag_ok(tt, NUM_MEM_TAGS);

    // Response path
    logic [NUM_MEM_TAGS:0] owner_valid;
    OWNER_T                owner [NUM_MEM_TAGS:0];

    MEM_TAG dt;
    logic   dt_live, resp_hit, resp_miss;
    OWNER_T resp_owner;
    assign dt         = bus.mem2proc_data_tag;
    assign dt_live    = tag_ok(dt, NUM_MEM_TAGS);
    assign resp_hit   = dt_live && owner_valid[dt];
    assign resp_owner = dt_live ? owner[dt] : FETCH;
    assign resp_miss  = (dt != '0) && !resp_hit;

    logic fetch_alloc, dcache_alloc, fetch_free, dcache_free;
    assign fetch_alloc  = load_acc && fetch_grant;
    assign dcache_alloc = load_acc && dcache_grant;
    assign fetch_free   = resp_hit && (resp_owner == FETCH);
    assign dcache_free  = resp_hit && (resp_owner == DCACHE);

    // Outputs
    assign bus.fetch_grant            = fetch_grant;
    assign bus.dcache_grant           = dcache_grant;
    assign bus.proc2mem_command       = cmd;
    assign bus.proc2mem_addr          = addr;
    assign bus.proc2mem_data          = wdata;
    assign bus.fetch_transaction_tag  = (accepted && fetch_grant)  ? tt : '0;
    assign bus.dcache_transaction_tag = (accepted && dcache_grant) ? tt : '0;
    assign bus.fetch_data_tag         = fetch_free  ? dt : '0;
    assign bus.dcache_data_tag        = dcache_free ? dt : '0;
    assign bus.fetch_data             = bus.mem2proc_data;
    assign bus.dcache_data            = bus.mem2proc_data;

    logic [CNT_W-1:0] fetch_out, dcache_out;
    logic             err_q;
    assign bus.fetch_outstanding  = fetch_out;
    assign bus.dcache_outstanding = dcache_out;
    assign bus.error              = err_q;

    // State
    always_ff @(posedge clock) begin
        if (reset) begin
            streak      <= '0;
            owner_valid <= '0;
            fetch_out   <= '0;
            dcache_out  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (dcache_grant)
                streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
            else
                streak <= '0;

            // Free before allocate so a same-cycle reuse of the tag keeps
            // the new owner.
            if (resp_hit) owner_valid[dt] <= 1'b0;
            if (load_acc) owner_valid[tt] <= 1'b1;

            fetch_out  <= fetch_out  + CNT_W'(fetch_alloc)  - CNT_W'(fetch_free);
            dcache_out <= dcache_out + CNT_W'(dcache_alloc) - CNT_W'(dcache_free);

            if (resp_miss) err_q <= 1'b1;
        end
    end

    // Owner field is qualified by owner_valid, so it needs no reset.
    always_ff @(posedge clock) begin
        if (load_acc) owner[tt] <= dcache_grant ? DCACHE : FETCH;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter. Inputs are
// driven #1 after posedge, outputs checked #2 after posedge.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.NUM_MEM_TAGS(NUM_MEM_TAGS), .STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.fetch_mem_en             = 1'b0;
        bus.fetch_mem_addr           = '0;
        bus.dcache_req               = 1'b0;
        bus.dcache_command           = MEM_NONE;
        bus.dcache_addr              = '0;
        bus.dcache_store_data        = '0;
        bus.mem2proc_transaction_tag = '0;
        bus.mem2proc_data_tag        = '0;
        bus.mem2proc_data            = '0;
    endtask

    // Advance to the next cycle's drive point.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_load(input ADDR a, input MEM_TAG t);
        idle_inputs();
        bus.fetch_mem_en             = 1'b1;
        bus.fetch_mem_addr           = a;
        bus.mem2proc_transaction_tag = t;
    endtask

    task automatic dcache_op(input MEM_COMMAND c, input ADDR a, input MEM_BLOCK d, input MEM_TAG t);
        idle_inputs();
        bus.dcache_req               = 1'b1;
        bus.dcache_command           = c;
        bus.dcache_addr              = a;
        bus.dcache_store_data        = d;
        bus.mem2proc_transaction_tag = t;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        // reset state
        check("rst_fgrant", 64'(bus.fetch_grant), 64'd1);
        check("rst_dgrant", 64'(bus.dcache_grant), 64'd0);
        check("rst_cmd",    64'(bus.proc2mem_command), 64'(MEM_NONE));
        check("rst_addr",   64'(bus.proc2mem_addr), 64'd0);
        check("rst_ftt",    64'(bus.fetch_transaction_tag), 64'd0);
        check("rst_dtt",    64'(bus.dcache_transaction_tag), 64'd0);
        check("rst_fout",   64'(bus.fetch_outstanding), 64'd0);
        check("rst_dout",   64'(bus.dcache_outstanding), 64'd0);
        check("rst_err",    64'(bus.error), 64'd0);

        // idle fetch load, tag 3
        step();
        fetch_load(32'h100, 4'd3);
        #1;
        check("idle_cmd",  64'(bus.proc2mem_command), 64'(MEM_LOAD));
        check("idle_addr", 64'(bus.proc2mem_addr), 64'h100);
        check("idle_ftt",  64'(bus.fetch_transaction_tag), 64'd3);
        check("idle_dtt",  64'(bus.dcache_transaction_tag), 64'd0);
        step();
        idle_inputs();
        #1;
        check("idle_fout1", 64'(bus.fetch_outstanding), 64'd1);
        bus.mem2proc_data_tag = 4'd3;
        bus.mem2proc_data     = 64'hCAFE_0003;
        #1;
        check("idle_fdt",   64'(bus.fetch_data_tag), 64'd3);
        check("idle_ddt",   64'(bus.dcache_data_tag), 64'd0);
        check("idle_fdata", bus.fetch_data, 64'hCAFE_0003);
        step();
        idle_inputs();
        #1;
        check("idle_fout0", 64'(bus.fetch_outstanding), 64'd0);
        check("idle_err",   64'(bus.error), 64'd0);

        // starvation: 4 dcache cycles, 1 forced fetch, dcache resumes
        for (int i = 0; i < 6; i++) begin
            step();
            dcache_op(MEM_LOAD, 32'h40, '0, 4'd0);
            #1;
            check($sformatf("starve_dgrant%0d", i), 64'(bus.dcache_grant), (i == 4) ? 64'd0 : 64'd1);
            check($sformatf("starve_fgrant%0d", i), 64'(bus.fetch_grant),  (i == 4) ? 64'd1 : 64'd0);
        end
        step();
        idle_inputs();   // one fetch cycle clears the streak

        // rejection
        step();
        dcache_op(MEM_LOAD, 32'h300, '0, 4'd0);
        #1;
        check("rej_dgrant", 64'(bus.dcache_grant), 64'd1);
        check("rej_dtt",    64'(bus.dcache_transaction_tag), 64'd0);
        step();
        idle_inputs();
        #1;
        check("rej_dout", 64'(bus.dcache_outstanding), 64'd0);

        // store, then orphan response for tag 5
        step();
        dcache_op(MEM_STORE, 32'h200, 64'hDEAD_BEEF, 4'd5);
        #1;
        check("st_cmd",  64'(bus.proc2mem_command), 64'(MEM_STORE));
        check("st_addr", 64'(bus.proc2mem_addr), 64'h200);
        check("st_data", bus.proc2mem_data, 64'hDEAD_BEEF);
        check("st_dtt",  64'(bus.dcache_transaction_tag), 64'd5);
        check("st_ftt",  64'(bus.fetch_transaction_tag), 64'd0);
        step();
        idle_inputs();
        #1;
        check("st_dout", 64'(bus.dcache_outstanding), 64'd0);
        bus.mem2proc_data_tag = 4'd5;
        #1;
        check("st_fdt", 64'(bus.fetch_data_tag), 64'd0);
        check("st_ddt", 64'(bus.dcache_data_tag), 64'd0);
        step();
        idle_inputs();
        #1;
        check("st_err", 64'(bus.error), 64'd1);

        // same-tag reuse: fetch owns 7, freed while dcache reallocates 7
        step();
        fetch_load(32'h180, 4'd7);
        #1;
        check("reuse_ftt", 64'(bus.fetch_transaction_tag), 64'd7);
        step();
        dcache_op(MEM_LOAD, 32'h280, '0, 4'd7);
        bus.mem2proc_data_tag = 4'd7;
        #1;
        check("reuse_fdt", 64'(bus.fetch_data_tag), 64'd7);
        check("reuse_ddt", 64'(bus.dcache_data_tag), 64'd0);
        check("reuse_dtt", 64'(bus.dcache_transaction_tag), 64'd7);
        step();
        idle_inputs();
        #1;
        check("reuse_fout", 64'(bus.fetch_outstanding), 64'd0);
        check("reuse_dout", 64'(bus.dcache_outstanding), 64'd1);
        bus.mem2proc_data_tag = 4'd7;
        #1;
        check("reuse_ddt2", 64'(bus.dcache_data_tag), 64'd7);
        check("reuse_fdt2", 64'(bus.fetch_data_tag), 64'd0);
        step();
        idle_inputs();
        #1;
        check("reuse_dout0", 64'(bus.dcache_outstanding), 64'd0);

        // reset mid-flight
        step();
        fetch_load(32'h500, 4'd1);
        step();
        dcache_op(MEM_LOAD, 32'h600, '0, 4'd2);
        step();
        idle_inputs();
        #1;
        check("mid_fout", 64'(bus.fetch_outstanding), 64'd1);
        check("mid_dout", 64'(bus.dcache_outstanding), 64'd1);
        reset = 1'b1;
        bus.mem2proc_data_tag = 4'd1;
        #1;
        check("mid_rst_fdt", 64'(bus.fetch_data_tag), 64'd1);
        step();
        reset = 1'b0;
        idle_inputs();
        #1;
        check("mid_fout0", 64'(bus.fetch_outstanding), 64'd0);
        check("mid_dout0", 64'(bus.dcache_outstanding), 64'd0);
        check("mid_err0",  64'(bus.error), 64'd0);
        bus.mem2proc_data_tag = 4'd2;
        #1;
        check("mid_ddt", 64'(bus.dcache_data_tag), 64'd0);
        check("mid_fdt", 64'(bus.fetch_data_tag), 64'd0);
        step();
        idle_inputs();
        #1;
        check("mid_err1", 64'(bus.error), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side arbiter and response router between the processor and main memory. It grants the single memory port to either the instruction fetch unit or the data cache each cycle and forwards the winner's request with zero latency. It hands the memory's transaction tag back to the winning client and records which client owns each outstanding load tag. When data returns, it routes the tag to the owner only.

## Interface
- `NUM_MEM_TAGS`, default `` `NUM_MEM_TAGS ``: number of memory tags; tags run 1..NUM_MEM_TAGS, and 0 means none.
- `STARVE_LIMIT`, default 4: maximum number of consecutive dcache-granted cycles before fetch gets one forced grant cycle.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `fetch_mem_en`  in  1  fetch load request; only meaningful while `fetch_grant` is high.
- `fetch_mem_addr`  in  ADDR  fetch block address.
- `fetch_grant`  out  1  fetch owns the memory port this cycle (drives fetch `arbiter_signal`).
- `fetch_transaction_tag`  out  MEM_TAG  tag accepted for the fetch request, else 0.
- `fetch_data_tag`  out  MEM_TAG  returning tag when fetch owns it, else 0.
- `fetch_data`  out  MEM_BLOCK  returning data, broadcast.
- `dcache_req`  in  1  dcache wants the port.
- `dcache_command`  in  MEM_COMMAND  MEM_LOAD or MEM_STORE.
- `dcache_addr`  in  ADDR  dcache block address.
- `dcache_store_data`  in  MEM_BLOCK  store data.
- `dcache_grant`  out  1  dcache owns the port this cycle.
- `dcache_transaction_tag`  out  MEM_TAG  tag accepted for the dcache request, else 0.
- `dcache_data_tag`  out  MEM_TAG  returning tag when dcache owns it, else 0.
- `dcache_data`  out  MEM_BLOCK  returning data, broadcast.
- `proc2mem_command`  out  MEM_COMMAND  command to memory.
- `proc2mem_addr`  out  ADDR  address to memory.
- `proc2mem_data`  out  MEM_BLOCK  store data to memory.
- `mem2proc_transaction_tag`  in  MEM_TAG  tag for the current command; 0 means rejected.
- `mem2proc_data_tag`  in  MEM_TAG  completed-load tag; 0 means none.
- `mem2proc_data`  in  MEM_BLOCK  completed-load data.
- `fetch_outstanding`, `dcache_outstanding`  out  clog2(NUM_MEM_TAGS+1)  number of loads in flight per client.
- `error`  out  1  sticky flag: a response arrived for a tag with no owner.

## Operation
- **Grant rule.**
  - `dcache_grant = dcache_req & (streak != STARVE_LIMIT)`.
  - `fetch_grant = ~dcache_grant`.
  - Grants are computed from registered `streak` and `dcache_req` only, never from `fetch_mem_en`, so there is no combinational loop through fetch.
- **Streak counter.**
  - Increments (saturating at STARVE_LIMIT) on each `dcache_grant` cycle.
  - Clears to 0 on each `fetch_grant` cycle.
- **Bus mux.**
  - If `dcache_grant`: drive `dcache_command`, `dcache_addr`, `dcache_store_data`.
  - Else if `fetch_mem_en`: drive MEM_LOAD, `fetch_mem_addr`, data 0.
  - Else: MEM_NONE, address 0, data 0.
  - `fetch_mem_en` is ignored while `fetch_grant` is low.
- **Acceptance.** A request is accepted when `proc2mem_command != MEM_NONE` and `mem2proc_transaction_tag != 0`.
  - The tag goes to the winner's `*_transaction_tag`; the other client sees 0.
  - A rejected request returns 0; the client retries.
- **Owner table.** Per tag: `owner_valid` plus `owner` (FETCH/DCACHE).
  - An accepted MEM_LOAD sets the entry.
  - An accepted MEM_STORE records nothing, since stores get no data response.
- **Response.** When `mem2proc_data_tag = t != 0`:
  - If `owner_valid[t]`: drive `t` on the owner's `*_data_tag` and 0 on the other; clear the entry at the clock edge.
  - If not valid: both data tags are 0, and `error` is set.
- **Outstanding counters.** +1 on an accepted load and −1 on a routed response, per client; both in the same cycle means no change.

## Timing
- Request path and response path are combinational, with 0-cycle latency.
- Owner table, counters, `streak` and `error` update at the posedge.
- **Simultaneous free and reallocate of the same tag:** the new allocation wins, so the entry ends valid with the new owner.
- **Response during reset cycle:** routed by the pre-reset table output; the table, counters, `streak` and `error` all clear.
- **Response arriving after reset** for a pre-reset tag: dropped, and `error` is set.
- **Reset values:**
  - Registered: `streak`=0, table invalid, outstanding counters 0, `error`=0.
  - Combinational outputs with `dcache_req`=0 and all memory inputs 0: `fetch_grant`=1, `dcache_grant`=0, command MEM_NONE, address/data 0, all tags 0.
- **Stores:** never increment the counters.

## Structure
- `OWNER_T` enum (FETCH, DCACHE) belongs in `sys_defs.svh`.
- ADDR, MEM_TAG, MEM_BLOCK and MEM_COMMAND already live there.
- Single module; no sub-module.

## Test plan
- **Idle:** `dcache_req`=0, `fetch_mem_en`=1 to 0x100, mem tag 3 → MEM_LOAD 0x100, `fetch_transaction_tag`=3, `fetch_outstanding`=1. Then `mem2proc_data_tag`=3 → `fetch_data_tag`=3, `dcache_data_tag`=0, counter back to 0.
- **Priority and starvation:** `dcache_req` held high with STARVE_LIMIT=4 → `dcache_grant` for 4 cycles, `fetch_grant` in the 5th, then dcache resumes.
- **Rejection:** mem tag 0 on a granted dcache load → `dcache_transaction_tag`=0, table and counters unchanged.
- **Store:** dcache MEM_STORE 0x200 accepted with tag 5 → no table entry. Then data_tag 5 → `error`=1, both data tags 0.
- **Same-tag reuse:** data_tag 7 (owner FETCH) and a new dcache load accepted with tag 7 in the same cycle → `fetch_data_tag`=7; a later data_tag 7 routes to dcache.
- **Reset mid-flight:** two loads outstanding, reset → counters 0, `error`=0. A subsequent response is dropped and `error`=1.
